uart_tx: RTL and testbench
==========================

# uart_tx

UART serial transmitter: the transmit-side counterpart of the block's receive path. It accepts one parallel byte through a valid handshake and shifts it out as a standard asynchronous frame: start bit, LSB-first data, optional parity, then a stop bit. Bit time is set by the same run-time `prescale` value the receiver uses, so both directions share one oversampled clock domain. It sits between the ALU result path and the serial pin.

## Interface

Parameters:
- `frame_data`, 8: data bits per frame.
- `sampling_bits`, 6: width of `prescale` and of the internal cycle counter.
- `bit_cnt_w`, 4: width of the internal bit counter.

Ports:
- `clk`  in  1  clock. One clock; everything is synchronous to it.
- `rst`  in  1  reset. Asynchronous, active-high.
- `p_data`  in  `frame_data`  parallel byte to send.
- `data_valid`  in  1  request to send `p_data`.
- `par_en`  in  1  1 means a parity bit follows the data.
- `par_typ`  in  1  parity type: 0 even, 1 odd.
- `prescale`  in  `sampling_bits`  `clk` cycles per bit.
- `tx_out`  out  1  serial line, registered, idles high.
- `busy`  out  1  high while a frame is in flight, registered.

## Operation

- States:
  - IDLE: `tx_out`=1, `busy`=0.
  - START: drives 0.
  - DATA: drives `data[bit]`, LSB first, for `frame_data` bits.
  - PARITY: drives the parity bit.
  - STOP: drives 1.
- Acceptance:
  - `data_valid`=1 while in IDLE captures `p_data`, `par_en`, `par_typ` and `prescale` into shadow registers, then moves to START.
  - Inputs may change freely after capture.
  - `data_valid` is ignored while busy, except in the final STOP cycle (see back-to-back below).
- Bit timing:
  - A cycle counter runs 0..P-1 per bit, where P is the captured `prescale`.
  - P=0 is treated as P=1.
  - The state or bit index advances when the counter reaches P-1.
  - Counter and bit index clear on every state change.
- Transitions:
  - START goes to DATA.
  - DATA advances after bit `frame_data`-1: to PARITY if the captured `par_en` is 1, otherwise to STOP.
  - PARITY goes to STOP.
  - STOP goes to IDLE, or straight to START on a back-to-back request.
- Parity bit = XOR-reduction of the captured data, XOR the captured `par_typ`.
- Back-to-back: `data_valid`=1 in the last cycle of STOP captures a new frame. START follows with no idle gap, and `busy` stays 1.
- Unused state encodings return to IDLE on the next cycle.

## Timing

- Reset values: `tx_out`=1, `busy`=0, state IDLE, counters 0.
- Reset mid-frame: asserting `rst` forces `tx_out`=1 and `busy`=0 immediately, without waiting for a clock edge. The frame is discarded and nothing is resumed after reset.
- Latency: `data_valid` is sampled at edge N, and `tx_out` falls and `busy` rises at edge N+1.
- Frame length: P×(`frame_data`+2) cycles, plus P more when parity is enabled.
  - At P=8 with 8 data bits: 80 cycles without parity, 88 with.
- `busy` falls one cycle after the last stop cycle, unless a back-to-back frame was accepted.
- Each bit is held for exactly P cycles, and `tx_out` is glitch-free because it is a flop output.
- A change on `prescale` mid-frame has no effect; the new value applies from the next acceptance.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- Defined: `par_en` and `par_typ` behave as specified above.
- Undefined:
  - The PARITY state and the parity logic are not built.
  - `par_en` and `par_typ` are ignored.
  - Every frame is start + data + stop, P×(`frame_data`+2) cycles.

## Test plan

1. Reset release, then `p_data`=0xA5, P=8, `par_en`=0 → `tx_out` bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; `busy` high for exactly 80 cycles.
2. `p_data`=0xA5, P=8, `par_en`=1: with `par_typ`=0 the parity bit is 0; with `par_typ`=1 the parity bit is 1. Frame length 88 cycles. Repeat with 0x01 and `par_typ`=0 → parity bit 1.
3. `data_valid` held high with 0x3C then 0xC3 supplied in the final STOP cycle → second start bit begins on the next cycle; `busy` never drops; a `p_data` change during the first frame does not corrupt it.
4. `data_valid` pulsed mid-frame with 0xFF → ignored; the original byte completes unchanged.
5. `rst` asserted at cycle 30 of a frame → `tx_out`=1 and `busy`=0 immediately, before the next clock edge; after release, a new 0x55 frame transmits correctly.
6. Compile without `UART_TX_PARITY_EN`, `par_en`=1, 0xA5, P=4 → 40-cycle frame with no parity bit. Also check P=0 → 1 cycle per bit, 10-cycle frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; bit time = prescale clk cycles.
// Parity support is built only when UART_TX_PARITY_EN is defined; otherwise par_en/par_typ are ignored.
module uart_tx #(
  parameter int unsigned frame_data    = 8,
  parameter int unsigned sampling_bits = 6,
  parameter int unsigned bit_cnt_w     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [frame_data-1:0]    p_data,
  input  logic                     data_valid,
  input  logic                     par_en,
  input  logic                     par_typ,
  input  logic [sampling_bits-1:0] prescale,
  output logic                     tx_out,
  output logic                     busy
);

  localparam logic [bit_cnt_w-1:0] last_bit = bit_cnt_w'(frame_data - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [sampling_bits-1:0] cnt_q, cnt_d;
  logic [bit_cnt_w-1:0]     bit_q, bit_d;
  logic [frame_data-1:0]    shift_q, shift_d;
  logic [sampling_bits-1:0] presc_q, presc_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     load_c;
  logic                     tick_c;
  logic [sampling_bits-1:0] last_cnt_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity_inputs;
  assign unused_parity_inputs = ^{par_en, par_typ};
`endif

  // A captured prescale of 0 behaves like 1: every cycle is the last of its bit.
  assign last_cnt_c = (presc_q == '0) ? '0 : presc_q - sampling_bits'(1);
  assign tick_c     = (cnt_q == last_cnt_c);

  // State, counters, shadow registers and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      presc_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      presc_q <= presc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is resolved at capture so later input changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load_c) begin
      par_en_q  <= par_en;
      par_bit_q <= (^p_data) ^ par_typ;
    end
  end
`endif

  // Next-state logic; line outputs are derived from the current state and registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + sampling_bits'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    presc_d = presc_q;
    load_c  = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        busy_d = 1'b0;
        if (data_valid) begin
          load_c  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (tick_c) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (tick_c) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == last_bit) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + bit_cnt_w'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_bit_q;
        if (tick_c) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (tick_c) begin
          cnt_d = '0;
          // A request in the final stop cycle chains straight into the next start bit.
          if (data_valid) begin
            load_c  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (load_c) begin
      shift_d = p_data;
      presc_d = prescale;
      cnt_d   = '0;
      bit_d   = '0;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle expected line/busy values are queued as frames are
// requested and popped one per clock; table-driven frames plus hand-written corner sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  uart_tx #(.frame_data(8), .sampling_bits(6), .bit_cnt_w(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tx;
    logic bz;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] presc;
    int         len;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock: sample 1 time unit after the edge and compare against the head of the scoreboard.
  task automatic step(output logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    bz = busy;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_bit("tx_out", tx_out, e.tx);
      check_bit("busy", busy, e.bz);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.tx = 1'b1;
    e.bz = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] presc);
    logic bits[$];
    exp_t e;
    int   p;
    p = (presc == 6'd0) ? 1 : int'(presc);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (pe) bits.push_back((^d) ^ pt);
`else
    if (pe && pt) bits.push_back(1'b1);
    if (pe && pt) void'(bits.pop_back());
`endif
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < p; c++) begin
        e.tx = bits[b];
        e.bz = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Pop every remaining expectation, counting the cycles that show busy high.
  task automatic drain(output int busy_cycles);
    logic bz;
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      step(bz);
      if (bz) busy_cycles++;
    end
  endtask

  // Request one frame (one-cycle data_valid), then scramble the inputs while it is in flight.
  task automatic send(input vec_t v);
    logic bz;
    int   bc;
    p_data     = v.data;
    par_en     = v.pe;
    par_typ    = v.pt;
    prescale   = v.presc;
    data_valid = 1'b1;
    push_idle();
    push_frame(v.data, v.pe, v.pt, v.presc);
    push_idle();
    step(bz);
    data_valid = 1'b0;
    p_data     = 8'($urandom);
    par_typ    = ~v.pt;
    prescale   = 6'($urandom_range(1, 63));
    drain(bc);
    check_int("frame_len", bc, v.len);
  endtask

  vec_t vecs[8];
  int   plen8;
  int   plen4;

  initial begin
    logic bz;
    int   bc;
    vec_t v;

`ifdef UART_TX_PARITY_EN
    plen8 = 88;
    plen4 = 48;
`else
    plen8 = 80;
    plen4 = 40;
`endif
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, presc: 6'd8, len: 80};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, presc: 6'd8, len: plen8};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, presc: 6'd8, len: plen8};
    vecs[3] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, presc: 6'd8, len: plen8};
    vecs[4] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, presc: 6'd4, len: plen4};
    vecs[5] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, presc: 6'd0, len: 10};
    vecs[6] = '{data: 8'hFF, pe: 1'b0, pt: 1'b0, presc: 6'd3, len: 30};
    vecs[7] = '{data: 8'h00, pe: 1'b0, pt: 1'b1, presc: 6'd1, len: 10};

    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx", tx_out, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    rst = 1'b0;
    push_idle();
    push_idle();
    step(bz);
    step(bz);

    foreach (vecs[i]) send(vecs[i]);

    // Back-to-back: valid held high, next byte presented during the first frame.
    p_data     = 8'h3C;
    par_en     = 1'b0;
    prescale   = 6'd8;
    data_valid = 1'b1;
    push_idle();
    push_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    push_frame(8'hC3, 1'b0, 1'b0, 6'd8);
    push_idle();
    step(bz);
    bc = 0;
    for (int k = 0; k < 130; k++) begin
      step(bz);
      if (bz) bc++;
      if (k == 10) p_data = 8'hC3;
      if (k == 120) data_valid = 1'b0;
    end
    begin
      int rest;
      drain(rest);
      bc += rest;
    end
    check_int("b2b_busy_len", bc, 160);

    // Mid-frame request is ignored, as is a prescale change.
    p_data     = 8'h96;
    prescale   = 6'd5;
    data_valid = 1'b1;
    push_idle();
    push_frame(8'h96, 1'b0, 1'b0, 6'd5);
    push_idle();
    step(bz);
    data_valid = 1'b0;
    repeat (20) step(bz);
    p_data     = 8'hFF;
    prescale   = 6'd2;
    data_valid = 1'b1;
    step(bz);
    data_valid = 1'b0;
    drain(bc);
    check_int("ignored_req_len", bc, 50 - 21);

    // Reset in the middle of a frame takes effect without a clock edge.
    p_data     = 8'h0F;
    prescale   = 6'd8;
    data_valid = 1'b1;
    push_idle();
    push_frame(8'h0F, 1'b0, 1'b0, 6'd8);
    step(bz);
    data_valid = 1'b0;
    repeat (30) step(bz);
    check_bit("pre_reset_busy", busy, 1'b1);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check_bit("async_rst_tx", tx_out, 1'b1);
    check_bit("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check_bit("rst_hold_busy", busy, 1'b0);
    rst = 1'b0;
    push_idle();
    step(bz);
    v = '{data: 8'h55, pe: 1'b0, pt: 1'b0, presc: 6'd8, len: 80};
    send(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d queued expected 0", exp_q.size());
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
